// File: rtl/encoder_pkg.sv
// Definitions shared between the request serializer and the priority encoder stage.
package encoder_pkg;

   localparam int ENC_W = 16;
   localparam int IDX_W = $clog2(ENC_W);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } ser_state_t;

endpackage

// File: rtl/onehot_req_serializer_lsb_isolate.sv
// Lowest-set-bit isolation: returns the one-hot of the lowest set bit of a vector,
// plus a flag that is high when the vector has exactly one bit set.
module lsb_isolate #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_vec,
   output logic [W-1:0] o_lsb,
   output logic         o_single
);

   logic [W-1:0] w_minus1;

   // Two's-complement trick: x & -x keeps only the lowest set bit.
   assign o_lsb    = i_vec & (~i_vec + W'(1));
   assign w_minus1 = i_vec - W'(1);
   assign o_single = (i_vec != '0) && ((i_vec & w_minus1) == '0);

endmodule

// File: rtl/onehot_req_serializer.sv
// Accepts a request bitmap and replays its set bits as one-hot words, lowest index first,
// so the downstream priority encoder only ever sees a legal one-hot input.
module onehot_req_serializer
   import encoder_pkg::*;
#(
   parameter int W     = ENC_W,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_bitmap,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_onehot,
   output logic             out_last,
   output logic [CNT_W-1:0] sent_cnt,
   output logic             empty_batch
);

   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   logic [W-1:0]     r_pending;
   logic [CNT_W-1:0] r_sent_cnt;
   logic             r_empty_batch;
   logic [W-1:0]     w_lsb;
   logic             w_single;
   logic             w_in_xfer;
   logic             w_out_xfer;

   lsb_isolate #(
      .W(W)
   ) u_lsb (
      .i_vec   (r_pending),
      .o_lsb   (w_lsb),
      .o_single(w_single)
   );

   assign w_in_xfer  = in_valid & clk_en & ~rst & (r_state == IDLE);
   assign w_out_xfer = out_ready & clk_en & (r_state == DRAIN);

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_onehot  = '0;
      out_last    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = clk_en & ~rst;
            if (w_in_xfer && (in_bitmap != '0)) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            out_valid  = 1'b1;
            out_onehot = w_lsb;
            out_last   = w_single;
            if (w_out_xfer && w_single) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (clk_en) begin
         r_state <= w_state_nxt;
      end
   end

   // A zero bitmap also lands here: pending stays empty and the FSM remains in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending     <= '0;
         r_sent_cnt    <= '0;
         r_empty_batch <= 1'b0;
      end else if (clk_en) begin
         if (w_in_xfer) begin
            r_pending  <= in_bitmap;
            r_sent_cnt <= '0;
         end else if (w_out_xfer) begin
            r_pending  <= r_pending & ~w_lsb;
            r_sent_cnt <= r_sent_cnt + CNT_W'(1);
         end
         r_empty_batch <= w_in_xfer && (in_bitmap == '0);
      end
   end

   assign sent_cnt    = r_sent_cnt;
   assign empty_batch = r_empty_batch;

endmodule

// File: doc/onehot_req_serializer.md
Name: onehot_req_serializer

Overview:
- Upstream feeder for the priority encoder stage.
- Accepts a W-bit request bitmap through a valid/ready handshake and holds it as a pending mask.
- Emits the set bits one at a time as one-hot words, lowest index first, so the encoder always sees a legal one-hot input.
- Shares the encoder's clk and clk_en, so both stages advance on the same enabled cycles.

Parameters:
- W, 16, bitmap and one-hot width; must match the encoder input width, and W >= 2.
- CNT_W, $clog2(W+1), width of the emitted-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  clock enable; when low, all state is frozen and no transfer completes.
- in_valid  in  1  in_bitmap is valid.
- in_ready  out  1  block can accept a bitmap.
- in_bitmap  in  W  request bitmap.
- out_valid  out  1  out_onehot is valid.
- out_ready  in  1  downstream (encoder side) accepts the word.
- out_onehot  out  W  lowest pending request, exactly one bit set whenever out_valid=1.
- out_last  out  1  current word is the final one of the batch.
- sent_cnt  out  CNT_W  words transferred in the current batch.
- empty_batch  out  1  one-cycle pulse after an all-zero bitmap is accepted.

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst).
- Transfer definitions:
  - Input transfer: in_valid & in_ready & clk_en.
  - Output transfer: out_valid & out_ready & clk_en.
  - Any valid & ready cycle with clk_en=0 is not a transfer.
- Reset values:
  - state=IDLE, pending=0, sent_cnt=0, empty_batch=0.
  - out_valid=0, out_onehot=0, out_last=0.
  - in_ready is held 0 while rst=1.
  - Reset mid-batch discards the pending mask immediately; no partial word is emitted afterwards.
- States:
  - IDLE:
    - in_ready = clk_en.
    - Accepting a nonzero bitmap: pending <= in_bitmap, sent_cnt <= 0, go to DRAIN.
    - Accepting a zero bitmap: stay in IDLE, and empty_batch=1 on the next cycle only.
  - DRAIN:
    - in_ready=0; out_valid=1.
    - out_onehot = pending & (~pending + 1), i.e. the lowest set bit.
    - out_last = 1 when exactly one bit of pending is set (pending & (pending-1) == 0).
    - On an output transfer: pending <= pending & ~out_onehot, and sent_cnt increments.
    - If out_last=1 on that transfer, go to IDLE.
- Output timing:
  - out_valid, out_onehot and out_last are functions of registered state only; there is no combinational path from in_*.
  - in_ready depends only on state, rst and clk_en.
- Latency and throughput:
  - First out_valid appears the cycle after the input transfer.
  - One word per enabled cycle while out_ready=1.
  - One bubble cycle (IDLE) between batches, so a batch of N set bits occupies N+1 enabled cycles.
- Backpressure: while out_ready=0, out_onehot, out_last and sent_cnt hold stable.
- clk_en=0:
  - Registers hold and in_ready=0.
  - out_valid keeps its registered value, but no transfer occurs.
- sent_cnt:
  - Holds its final value in IDLE until the next input transfer clears it.
  - Never wraps, because it is bounded by W.
- in_valid during DRAIN is ignored; the upstream must hold its data (standard valid/ready rule).

Decomposition:
- Shared package encoder_pkg holds:
  - ENC_W = 16 and IDX_W = $clog2(ENC_W), shared with the encoder.
  - Typedef ser_state_t enum {IDLE, DRAIN}.
- One sub-module, lsb_isolate (combinational, parameter W):
  - Inputs: vector.
  - Outputs: lowest set bit one-hot, and a single-bit flag.
- FSM, pending register and counter stay in the top module.

Test Plan:
- Bitmap 0x0110 accepted, out_ready=1:
  - Next cycle: out_onehot=0x0010, out_last=0.
  - Then: 0x0100, out_last=1.
  - sent_cnt reads 2 after the batch.
  - in_ready returns to 1 one cycle later.
- Bitmap 0x8000:
  - Single word 0x8000 with out_last=1.
  - sent_cnt=1; the encoder downstream yields 15.
- Bitmap 0x0000:
  - empty_batch=1 for exactly one cycle.
  - out_valid stays 0; in_ready stays 1.
- Bitmap 0x00F0 with out_ready=0 for 3 cycles:
  - out_onehot holds 0x0010 and sent_cnt holds 0 throughout.
  - After release, 0x0010, 0x0020, 0x0040 and 0x0080 follow on consecutive cycles.
- Bitmap 0xFFFF with clk_en=0 for 2 cycles after the 4th transfer:
  - out_onehot holds 0x0010; sent_cnt holds 4.
  - Draining resumes; the batch totals 16 words.
- Bitmap 0xFFFF with rst pulsed after 5 transfers:
  - out_valid=0, out_onehot=0, sent_cnt=0 asynchronously.
  - A new bitmap 0x0003 after reset emits 0x0001 then 0x0002.
  - in_valid held during DRAIN is never accepted.
